logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, registered bitwise logic unit for the ALU datapath; successor to the fixed 32-bit XOR array.
- Operations: AND/OR/XOR/NOR/XNOR/ANDN on WIDTH-bit operands, plus an XOR-accumulate mode (running checksum) with load.
- Single output register stage with valid/ready handshake on both sides; produces result, parity and zero flags.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).
- ACC_INIT, 0, accumulator value after reset (WIDTH bits).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  unit can accept this cycle.
- op  input  3  operation select (see Behaviour).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result registers hold an unconsumed result.
- out_ready  input  1  downstream consumes result this cycle.
- result  output  WIDTH  registered result.
- parity  output  1  XOR-reduction of result (registered with result).
- zero  output  1  result == 0 (registered with result).
- acc  output  WIDTH  current accumulator value.

Behaviour:
- Op encoding: 000 a&b; 001 a|b; 010 a^b; 011 ~(a|b); 100 ~(a^b); 101 a&~b; 110 ACC_XOR; 111 ACC_LOAD.
- ACC_XOR: acc_next = acc ^ a ^ b; result = acc_next. ACC_LOAD: acc_next = a; result = a; b ignored.
- Ops 000-101 leave acc unchanged.
- Accept = in_valid && in_ready. in_ready = !out_valid || out_ready (combinational; full throughput).
- On accept: result, parity, zero and acc (if applicable) load at the next edge; out_valid = 1. Latency is exactly 1 cycle.
- If out_valid && out_ready && !in_valid: out_valid -> 0 next cycle. result, parity and zero hold their last values.
- If out_valid && !out_ready: in_ready = 0; result, parity, zero, acc and out_valid hold stable. No overwrite while stalled.
- Simultaneous consume and accept: the new result replaces the old one in the same edge and out_valid stays 1.
- Back-to-back ACC_XOR: each accepted op sees the acc updated by the previous accept. No hazard bubble.
- All bitwise ops are purely per-bit. No carries and no width growth; results are truncated/defined at WIDTH bits.
- parity = ^result. zero = (result == 0). Both are derived from the next-result value and registered together with it, never lagging.
- Reset (any cycle, including mid-stall): out_valid = 0, result = 0, parity = 0, zero = 1, acc = ACC_INIT. in_ready = 1 in the first cycle after reset.
- An input presented while reset = 1 is not accepted.
- Inputs are ignored when in_valid = 0; the unit is X-safe on a, b and op when in_valid = 0.

Test Plan:
- Reset, then a=0xF0F0_F0F0, b=0xFF00_FF00, ops 000..101 back-to-back with out_ready=1 -> results 0xF000_F000, 0xFFF0_FFF0, 0x0FF0_0FF0, 0x000F_000F, 0xF00F_F00F, 0x00F0_00F0. Each appears 1 cycle after accept and out_valid is continuous.
- ACC_LOAD a=0x1234_5678, then ACC_XOR (a=0xFFFF_0000, b=0) then ACC_XOR (a=0, b=0x0000_FFFF) -> results 0x1234_5678, 0xEDCB_5678, 0xEDCB_A987; acc tracks each result.
- Stall: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, result/acc unchanged, no accept. Release -> the pending input is accepted on the same cycle the old result is consumed.
- Flags: a=b=0xA5A5_A5A5 with XOR -> result 0, zero=1, parity=0. Then OR with a=1, b=0 -> zero=0, parity=1.
- Assert reset while out_valid=1 and acc=0xDEAD_BEEF -> next cycle out_valid=0, result=0, zero=1, acc=ACC_INIT.
- Re-run the first scenario with WIDTH=8 (a=0xF0, b=0xCC) -> AND 0xC0, XOR 0x3C, NOR 0x03. Results are width-correct with no X on the upper bits.

Source files
------------

// File: rtl/logic_unit_pipe.sv
//------------------------------------------------------------------------------
// Module  : logic_unit_pipe
// Brief   : Registered bitwise logic unit with XOR-accumulator, valid/ready
//           handshake on both sides, and parity/zero result flags.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module logic_unit_pipe #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             parity,
  output logic             zero,
  output logic [WIDTH-1:0] acc
);

  localparam logic [2:0] c_OP_AND      = 3'b000;
  localparam logic [2:0] c_OP_OR       = 3'b001;
  localparam logic [2:0] c_OP_XOR      = 3'b010;
  localparam logic [2:0] c_OP_NOR      = 3'b011;
  localparam logic [2:0] c_OP_XNOR     = 3'b100;
  localparam logic [2:0] c_OP_ANDN     = 3'b101;
  localparam logic [2:0] c_OP_ACC_XOR  = 3'b110;
  localparam logic [2:0] c_OP_ACC_LOAD = 3'b111;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_parity;
  logic             r_zero;
  logic [WIDTH-1:0] r_acc;

  logic             w_accept;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] w_acc_next;

  // A stalled result blocks new input so it can never be overwritten.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_result   = '0;
    w_acc_next = r_acc;
    case (op)
      c_OP_AND:      w_result = a & b;
      c_OP_OR:       w_result = a | b;
      c_OP_XOR:      w_result = a ^ b;
      c_OP_NOR:      w_result = ~(a | b);
      c_OP_XNOR:     w_result = ~(a ^ b);
      c_OP_ANDN:     w_result = a & ~b;
      c_OP_ACC_XOR: begin
        w_acc_next = r_acc ^ a ^ b;
        w_result   = w_acc_next;
      end
      c_OP_ACC_LOAD: begin
        w_acc_next = a;
        w_result   = a;
      end
      default:       w_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_parity    <= 1'b0;
      r_zero      <= 1'b1;
      r_acc       <= ACC_INIT;
    end else if (w_accept) begin
      // Flags come from the same next-result value so they never lag result.
      r_out_valid <= 1'b1;
      r_result    <= w_result;
      r_parity    <= ^w_result;
      r_zero      <= (w_result == '0);
      r_acc       <= w_acc_next;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign parity    = r_parity;
  assign zero      = r_zero;
  assign acc       = r_acc;

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
//------------------------------------------------------------------------------
// Module  : tb_logic_unit_pipe
// Brief   : Self-checking bench for logic_unit_pipe (32-bit and 8-bit builds).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_logic_unit_pipe;

  localparam logic [31:0] c_ACC_INIT = 32'h5A5A_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        parity;
  logic        zero;
  logic [31:0] acc;

  logic        reset8, in_valid8, in_ready8, out_valid8, out_ready8, parity8, zero8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, result8, acc8;

  int vectors = 0;
  int miscompares = 0;

  // reference state
  logic        m_valid;
  logic [31:0] m_result;
  logic [31:0] m_acc;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(32), .ACC_INIT(c_ACC_INIT)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .parity(parity), .zero(zero), .acc(acc)
  );

  logic_unit_pipe #(.WIDTH(8), .ACC_INIT(8'h00)) u_dut8 (
    .clk(clk), .reset(reset8), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .parity(parity8), .zero(zero8), .acc(acc8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Straight from the operation table: what the unit should compute.
  function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] x,
                                         input logic [31:0] y, input logic [31:0] ac);
    case (o)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~(x | y);
      3'd4:    return ~(x ^ y);
      3'd5:    return x & ~y;
      3'd6:    return ac ^ x ^ y;
      default: return x;
    endcase
  endfunction

  // One clock of the 32-bit unit: drive, check ready, clock, check outputs.
  task automatic step(input logic rst, input logic iv, input logic [2:0] o,
                      input logic [31:0] x, input logic [31:0] y, input logic ordy);
    logic exp_ready;
    reset = rst; in_valid = iv; out_ready = ordy;
    op = iv ? o : 3'bx; a = iv ? x : 'x; b = iv ? y : 'x;
    #1;
    exp_ready = !m_valid || ordy;
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_result = '0; m_acc = c_ACC_INIT;
    end else if (iv && exp_ready) begin
      m_result = ref_op(o, x, y, m_acc);
      if (o >= 3'd6) m_acc = m_result;
      m_valid = 1'b1;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    chk("result", {32'd0, result}, {32'd0, m_result});
    chk("parity", {63'd0, parity}, {63'd0, 1'($countones(m_result) % 2)});
    chk("zero", {63'd0, zero}, {63'd0, m_result == 32'd0});
    chk("acc", {32'd0, acc}, {32'd0, m_acc});
  endtask

  task automatic step8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] exp, input string tag);
    reset8 = 1'b0; in_valid8 = 1'b1; op8 = o; a8 = x; b8 = y; out_ready8 = 1'b1;
    @(posedge clk); #1;
    chk(tag, {56'd0, result8}, {56'd0, exp});
    chk("w8_valid", {63'd0, out_valid8}, 64'd1);
    chk("w8_no_x", {63'd0, $isunknown(result8)}, 64'd0);
  endtask

  localparam logic [31:0] c_EXP_BASIC [6] = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0,
                                              32'h000F_000F, 32'hF00F_F00F, 32'h00F0_00F0};

  initial begin
    m_valid = 1'b0; m_result = '0; m_acc = c_ACC_INIT;
    reset8 = 1'b1; in_valid8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; out_ready8 = 1'b1;

    // reset, with a valid input presented that must not be accepted
    step(1'b1, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'h0, 1'b1);
    step(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    chk("rst_zero", {63'd0, zero}, 64'd1);
    chk("rst_acc", {32'd0, acc}, {32'd0, c_ACC_INIT});

    // all plain ops back-to-back
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 3'(i), 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
      chk("basic_op", {32'd0, result}, {32'd0, c_EXP_BASIC[i]});
    end

    // accumulator chain
    step(1'b0, 1'b1, 3'd7, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    chk("acc_load", {32'd0, result}, {32'd0, 32'h1234_5678});
    step(1'b0, 1'b1, 3'd6, 32'hFFFF_0000, 32'h0, 1'b1);
    chk("acc_xor1", {32'd0, result}, {32'd0, 32'hEDCB_5678});
    step(1'b0, 1'b1, 3'd6, 32'h0, 32'h0000_FFFF, 1'b1);
    chk("acc_xor2", {32'd0, acc}, {32'd0, 32'hEDCB_A987});

    // stall for 3 cycles with a pending input, then release
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 3'd1, 32'h0000_0F00, 32'h0, 1'b0);
      chk("stall_hold", {32'd0, result}, {32'd0, 32'hEDCB_A987});
    end
    step(1'b0, 1'b1, 3'd1, 32'h0000_0F00, 32'h0, 1'b1);
    chk("stall_release", {32'd0, result}, {32'd0, 32'h0000_0F00});

    // flags
    step(1'b0, 1'b1, 3'd2, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1);
    chk("flag_zero1", {63'd0, zero}, 64'd1);
    step(1'b0, 1'b1, 3'd1, 32'h1, 32'h0, 1'b1);
    chk("flag_parity1", {63'd0, parity}, 64'd1);
    step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    chk("drain_hold", {32'd0, result}, {32'd0, 32'h1});

    // reset while stalled with a loaded accumulator
    step(1'b0, 1'b1, 3'd7, 32'hDEAD_BEEF, 32'h0, 1'b0);
    step(1'b0, 1'b1, 3'd0, 32'h1, 32'h1, 1'b0);
    step(1'b1, 1'b1, 3'd0, 32'h1, 32'h1, 1'b0);
    chk("midstall_rst_acc", {32'd0, acc}, {32'd0, c_ACC_INIT});

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), $urandom, $urandom, ($urandom_range(0, 3) != 0));
    end

    // 8-bit build
    @(posedge clk); #1;
    step8(3'd0, 8'hF0, 8'hCC, 8'hC0, "w8_and");
    step8(3'd2, 8'hF0, 8'hCC, 8'h3C, "w8_xor");
    step8(3'd3, 8'hF0, 8'hCC, 8'h03, "w8_nor");
    chk("w8_parity", {63'd0, parity8}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
